line_delay: RTL and testbench

RAM-backed, runtime-programmable delay line for the pixel pipeline. It accepts one sample per cycle while `in_valid` is high and returns the sample accepted `delay_len` accepted-samples earlier. Time advances only on accepted samples, not on every clock. It is the buffered, gap-tolerant counterpart to the register-chain delays. Filters use it to align a pixel with its neighbour one image line back (delay_len = line width) and to re-align long pipelines whose latency is set at run time.

---
 rtl/line_delay_pkg.sv | 26 ++
 rtl/line_delay_sdp_ram_rf.sv | 29 ++
 rtl/line_delay.sv | 114 +++++++++++
 tb/tb_line_delay.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/line_delay_pkg.sv
// Shared definitions for the pixel-pipeline delay blocks.
// Holds the default pixel width, clog2 and the control state type.
package line_delay_pkg;

    // Default pixel width: three 8-bit colour channels.
    localparam int PIX_W = 24;

    // Control states of the delay line.
    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } ld_state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/line_delay_sdp_ram_rf.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-first: a read to the address being written returns old data.
module sdp_ram_rf #(
    parameter int N     = 24,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [DEPTH];

    // Write and read share one edge; NBA ordering gives read-first.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_delay.sv
// Runtime-programmable, gap-tolerant delay line backed by a RAM.
// Returns the sample accepted delay_len accepted-samples earlier.
module line_delay
    import line_delay_pkg::*;
#(
    parameter int N     = PIX_W,
    parameter int DEPTH = 1024,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW:0]   delay_len,
    input  logic          in_valid,
    input  logic [N-1:0]  in,
    output logic          out_valid,
    output logic [N-1:0]  out
);

    localparam logic [AW:0] DMAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0] DONE = (AW + 1)'(1);

    logic [AW:0]   dl_new;
    logic [AW:0]   dl_q;
    logic [AW:0]   fill;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] raddr;
    logic [N-1:0]  rdata;
    logic          chg;
    logic          we;
    logic          re;
    logic          out_live;
    ld_state_t     state;

    // Clamp the requested delay into 1..DEPTH.
    always_comb begin
        dl_new = delay_len;
        if (delay_len == '0) begin
            dl_new = DONE;
        end else if (delay_len > DMAX) begin
            dl_new = DMAX;
        end
    end

    // Reset discards the accept; a delay change suppresses output.
    assign chg   = (dl_new != dl_q);
    assign we    = in_valid & ~rst;
    assign re    = we & ~chg & (state == RUN);
    assign raddr = wr_ptr - dl_q[AW-1:0];

    // Delayed sample is read at the accepting edge.
    sdp_ram_rf #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (in),
        .re    (re),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Write pointer advances only on accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Fill counter and FILL/RUN control; a delay change restarts the fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_q  <= dl_new;
            fill  <= '0;
            state <= FILL;
        end else begin
            dl_q <= dl_new;
            if (chg) begin
                fill <= in_valid ? DONE : '0;
                if (in_valid && dl_new == DONE) begin
                    state <= RUN;
                end else begin
                    state <= FILL;
                end
            end else if (in_valid && state == FILL) begin
                fill <= fill + 1'b1;
                if (fill + 1'b1 == dl_q) begin
                    state <= RUN;
                end
            end
        end
    end

    // Output strobe; out reads as zero until the first delayed sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_live  <= 1'b0;
        end else begin
            out_valid <= re;
            if (re) begin
                out_live <= 1'b1;
            end
        end
    end

    // The RAM read register holds between pulses, so out holds too.
    assign out = out_live ? rdata : '0;

endmodule

// File: tb/tb_line_delay.sv
// Bench for line_delay: vector table, directed corners, random stream.
// Reference model keeps a queue of samples accepted since the last restart.
module tb_line_delay;

    localparam int N     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic [AW:0]   delay_len;
    logic          in_valid;
    logic [N-1:0]  in_s;
    logic          out_valid;
    logic [N-1:0]  out_s;

    int n_chk;
    int n_fail;

    line_delay #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .delay_len (delay_len),
        .in_valid  (in_valid),
        .in        (in_s),
        .out_valid (out_valid),
        .out       (out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         r;
        logic         v;
        logic [AW:0]  d;
        logic [N-1:0] x;
        logic         eov;
        logic [N-1:0] eout;
    } vec_t;

    vec_t tbl[$];

    logic [N-1:0] hist[$];
    int           m_dl;
    logic         m_ov;
    logic [N-1:0] m_out;

    function automatic int clampd(input int d);
        if (d == 0) return 1;
        if (d > DEPTH) return DEPTH;
        return d;
    endfunction

    task automatic model(input logic r, input logic v,
                         input logic [AW:0] d, input logic [N-1:0] x);
        int nd;
        if (r) begin
            hist.delete();
            m_dl  = clampd(int'(d));
            m_ov  = 1'b0;
            m_out = '0;
        end else begin
            nd   = clampd(int'(d));
            m_ov = 1'b0;
            if (nd != m_dl) begin
                m_dl = nd;
                hist.delete();
                if (v) hist.push_back(x);
            end else if (v) begin
                if (hist.size() >= m_dl) begin
                    m_ov  = 1'b1;
                    m_out = hist[hist.size() - m_dl];
                end
                hist.push_back(x);
                if (hist.size() > 2 * DEPTH) void'(hist.pop_front());
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic v,
                       input logic [AW:0] d, input logic [N-1:0] x,
                       input bit use_model);
        rst       = r;
        in_valid  = v;
        delay_len = d;
        in_s      = x;
        @(posedge clk);
        model(r, v, d, x);
        #1;
        if (use_model) begin
            chk("model_ov", 32'(out_valid), 32'(m_ov));
            chk("model_out", 32'(out_s), 32'(m_out));
        end
    endtask

    task automatic add(input logic r, input logic v, input int d,
                       input int x, input logic eov, input int eout);
        vec_t e;
        e.r = r; e.v = v; e.d = (AW + 1)'(d); e.x = N'(x);
        e.eov = eov; e.eout = N'(eout);
        tbl.push_back(e);
    endtask

    initial begin
        logic [AW:0] rd;
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; delay_len = 4; in_s = '0;
        m_dl = 4; m_ov = 0; m_out = '0;

        add(1, 0, 4, 0,  0, 0);
        add(1, 1, 4, 99, 0, 0);
        for (int k = 1; k <= 4; k++) add(0, 1, 4, k, 0, 0);
        add(0, 1, 4, 5, 1, 1);
        add(0, 1, 4, 6, 1, 2);
        add(0, 1, 4, 7, 1, 3);
        add(0, 0, 4, 0, 0, 3);
        add(0, 1, 4, 8, 1, 4);
        add(1, 0, 0, 0,  0, 0);
        add(0, 1, 0, 50, 0, 0);
        add(0, 1, 0, 51, 1, 50);
        add(0, 1, 0, 52, 1, 51);
        add(0, 0, 0, 0,  0, 51);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].x, 1'b0);
            chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].eov));
            chk($sformatf("tbl%0d_out", i), 32'(out_s), 32'(tbl[i].eout));
        end

        // Sparse input: one accept in three.
        cyc(1, 0, 4, 0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            cyc(0, 1, 4, N'(k), 1'b1);
            cyc(0, 0, 4, 0, 1'b1);
            cyc(0, 0, 4, 0, 1'b1);
        end

        // Full-depth delay: read and write addresses coincide.
        cyc(1, 0, 16, 0, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            cyc(0, 1, 16, N'(k), 1'b1);
            if (k == 16) chk("dl16_not_yet", 32'(out_valid), 32'd0);
            if (k == 17) chk("dl16_first", 32'(out_s), 32'd1);
            if (k == 40) chk("dl16_last", 32'(out_s), 32'd24);
        end

        // Delay change 4 -> 2 on the accept of sample 20.
        cyc(1, 0, 4, 0, 1'b1);
        for (int k = 10; k <= 19; k++) cyc(0, 1, 4, N'(k), 1'b1);
        cyc(0, 1, 2, 20, 1'b1);
        chk("chg_s20_ov", 32'(out_valid), 32'd0);
        cyc(0, 1, 2, 21, 1'b1);
        chk("chg_s21_ov", 32'(out_valid), 32'd0);
        cyc(0, 1, 2, 22, 1'b1);
        chk("chg_s22_ov", 32'(out_valid), 32'd1);
        chk("chg_s22_out", 32'(out_s), 32'd20);
        cyc(0, 1, 2, 23, 1'b1);
        chk("chg_s23_out", 32'(out_s), 32'd21);

        // Reset pulse mid-stream, with an accept in the reset cycle.
        for (int k = 1; k <= 10; k++) cyc(0, 1, 4, N'(k), 1'b1);
        cyc(1, 1, 4, 77, 1'b1);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out_s), 32'd0);
        for (int k = 101; k <= 108; k++) begin
            cyc(0, 1, 4, N'(k), 1'b1);
            if (k == 104) chk("rst_4th_ov", 32'(out_valid), 32'd0);
            if (k == 105) chk("rst_5th_out", 32'(out_s), 32'd101);
        end

        // Over-range delay clamps to DEPTH.
        cyc(1, 0, 20, 0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            cyc(0, 1, 20, N'(k), 1'b1);
            if (k == 17) chk("dl20_first", 32'(out_s), 32'd1);
        end

        // Random stream with occasional delay changes and resets.
        rd = 5;
        cyc(1, 0, rd, 0, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) rd = (AW + 1)'($urandom_range(0, 20));
            cyc(logic'($urandom_range(0, 299) == 0),
                logic'($urandom_range(0, 3) != 0),
                rd, N'($urandom), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
